frame_writer: RTL and testbench
===============================

FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 12, pixel color bits.
- H_PIXELS, 320, frame width.
- V_PIXELS, 240, frame height.
- ADDR_LEN, 17, frame-buffer address bits; H_PIXELS*V_PIXELS <= 2^ADDR_LEN.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- pixel_valid  in  1  upstream pixel offered.
- pixel_ready  out  1  block accepts pixel this cycle.
- pixel_x  in  9  column.
- pixel_y  in  8  row.
- pixel_color  in  WIDTH  color.
- vblank  in  1  display vertical-blank flag, same clock domain.
- write_enable  out  1  frame-buffer write strobe.
- write_addr  out  ADDR_LEN  frame-buffer write address.
- write_data  out  WIDTH  frame-buffer write data.
- swap_buffers  out  1  one-cycle buffer flip, coincident with the first write of a new frame.
- frame_count  out  8  completed-and-swapped frames, wraps 255->0.
- range_error  out  1  sticky flag: out-of-range pixel dropped.

Function
REQ-003 A pixel SHALL be accepted on any cycle where pixel_valid && pixel_ready.
REQ-004 An accepted in-range pixel (x < H_PIXELS, y < V_PIXELS) SHALL produce write_enable=1 exactly one cycle later, with write_addr = y*H_PIXELS + x computed in ADDR_LEN bits and write_data = pixel_color.
REQ-005 write_enable SHALL be 0 on every cycle not covered by REQ-004; write_addr and write_data are don't-care when write_enable=0.
REQ-006 An accepted out-of-range pixel SHALL be dropped: no write, not counted, range_error set to 1 until reset.
REQ-007 pixel_cnt (internal, ADDR_LEN+1 bits) SHALL increment on each accepted in-range pixel; duplicates count.
REQ-008 State machine states SHALL be WRITING, WAIT_VBLANK and SWAP_ARMED.
REQ-009 In WRITING, pixel_ready=1; acceptance of the pixel making pixel_cnt reach H_PIXELS*V_PIXELS SHALL transition to WAIT_VBLANK next cycle and clear pixel_cnt.
REQ-010 In WAIT_VBLANK, pixel_ready=0; vblank=1 sampled in this state SHALL transition to SWAP_ARMED next cycle. A vblank already high on entry is honoured on the first WAIT_VBLANK cycle.
REQ-011 In SWAP_ARMED, pixel_ready=1; the next accepted pixel SHALL drive swap_buffers=1 on the same cycle as its write_enable (or alone, if out of range), SHALL increment frame_count, and SHALL return the state to WRITING. That pixel counts toward the new frame.
REQ-012 swap_buffers SHALL be high for exactly one cycle per completed frame and never otherwise.
REQ-013 pixel_ready SHALL be a registered output, derived only from state.
REQ-014 If H_PIXELS*V_PIXELS = 1, every in-range acceptance in WRITING SHALL complete a frame.

Reset
REQ-015 While rst=1, asynchronously and held: state=WRITING, pixel_cnt=0, write_enable=0, write_addr=0, write_data=0, swap_buffers=0, frame_count=0, range_error=0, pixel_ready=1 after release.
REQ-016 Reset mid-frame or in WAIT_VBLANK/SWAP_ARMED SHALL discard progress with no swap pulse. The first frame after reset SHALL be written without a swap.

Verification
REQ-017 Scenario 1: accept (x=5, y=2, color=0xABC) -> next cycle write_enable=1, write_addr=645, write_data=0xABC.
REQ-018 Scenario 2: 76800 in-range pixels with vblank=0 -> pixel_ready=0 from the cycle after the last accept, no further writes.
REQ-019 Scenario 3: continue from scenario 2, raise vblank for 1 cycle, then offer (0,0) -> exactly one cycle with swap_buffers=1 and write_enable=1, write_addr=0; frame_count=1.
REQ-020 Scenario 4: accept (320,0) then (0,240) -> no write_enable, pixel_cnt unchanged, range_error=1 and sticky.
REQ-021 Scenario 5: vblank held high while frame completes -> SWAP_ARMED reached 2 cycles after last accept, pixel_ready=1.
REQ-022 Scenario 6: assert rst in WAIT_VBLANK -> all outputs 0 immediately; after release, pixel_ready=1 and 76800 pixels are needed before the next swap.

Source files
------------

// File: rtl/frame_writer.sv
// ---------------------------------------------------------------------------
// frame_writer
//
// Accepts a stream of (x, y, color) pixels and turns each in-range pixel into
// a single frame-buffer write one cycle later, at address y*H_PIXELS + x.
// After a full frame's worth of in-range pixels the block stalls upstream,
// waits for the display's vertical blank, and then flips the frame buffers
// together with the first write of the next frame.
//
// Ports
//   clk           single clock, all logic on posedge
//   rst           asynchronous, active-high reset
//   pixel_valid   upstream pixel offered
//   pixel_ready   block accepts a pixel this cycle (registered, from state)
//   pixel_x       column
//   pixel_y       row
//   pixel_color   pixel color
//   vblank        display vertical-blank flag (same clock domain)
//   write_enable  frame-buffer write strobe
//   write_addr    frame-buffer write address
//   write_data    frame-buffer write data
//   swap_buffers  one-cycle buffer flip, with the first write of a new frame
//   frame_count   completed-and-swapped frames, wraps 255 -> 0
//   range_error   sticky: an out-of-range pixel was dropped
//
// State table
//   state        | meaning
//   WRITING      | accepting pixels of the current frame
//   WAIT_VBLANK  | frame complete, upstream stalled until vblank is seen
//   SWAP_ARMED   | next accepted pixel flips the buffers and starts a frame
// ---------------------------------------------------------------------------
module frame_writer #(
  parameter int WIDTH    = 12,
  parameter int H_PIXELS = 320,
  parameter int V_PIXELS = 240,
  parameter int ADDR_LEN = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pixel_valid,
  output logic                pixel_ready,
  input  logic [8:0]          pixel_x,
  input  logic [7:0]          pixel_y,
  input  logic [WIDTH-1:0]    pixel_color,
  input  logic                vblank,
  output logic                write_enable,
  output logic [ADDR_LEN-1:0] write_addr,
  output logic [WIDTH-1:0]    write_data,
  output logic                swap_buffers,
  output logic [7:0]          frame_count,
  output logic                range_error
);

  typedef enum logic [1:0] {
    WRITING     = 2'd0,
    WAIT_VBLANK = 2'd1,
    SWAP_ARMED  = 2'd2
  } state_t;

  localparam logic [ADDR_LEN:0]   FRAME_PIXELS = (ADDR_LEN+1)'(H_PIXELS * V_PIXELS);
  localparam logic [31:0]         H_LIM        = 32'(H_PIXELS);
  localparam logic [31:0]         V_LIM        = 32'(V_PIXELS);
  localparam logic [ADDR_LEN-1:0] H_STRIDE     = ADDR_LEN'(H_PIXELS);

  state_t               state_q, state_d;
  logic [ADDR_LEN:0]    cnt_q, cnt_d, cnt_inc;
  logic                 ready_q, ready_d;
  logic                 we_q, we_d;
  logic [ADDR_LEN-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 swap_q, swap_d;
  logic [7:0]           frame_q, frame_d;
  logic                 err_q, err_d;

  logic accept;
  logic in_range;
  logic frame_done;

  assign accept   = pixel_valid && ready_q;
  assign in_range = ({23'd0, pixel_x} < H_LIM) && ({24'd0, pixel_y} < V_LIM);
  assign cnt_inc  = cnt_q + (ADDR_LEN+1)'(1);

  // Only in-range acceptances advance the count. In SWAP_ARMED the counter
  // is already zero, so the swapping pixel is the first of the new frame and
  // a single-pixel frame completes on it just like in WRITING.
  assign frame_done = accept && in_range && (cnt_inc == FRAME_PIXELS);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WRITING;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      WRITING: begin
        if (frame_done) state_d = WAIT_VBLANK;
      end
      WAIT_VBLANK: begin
        if (vblank) state_d = SWAP_ARMED;
      end
      SWAP_ARMED: begin
        if (accept) state_d = frame_done ? WAIT_VBLANK : WRITING;
      end
      default: state_d = WRITING;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    we_d    = accept && in_range;
    addr_d  = addr_q;
    data_d  = data_q;
    swap_d  = accept && (state_q == SWAP_ARMED);
    frame_d = swap_d ? (frame_q + 8'd1) : frame_q;
    err_d   = err_q || (accept && !in_range);
    cnt_d   = cnt_q;

    if (we_d) begin
      addr_d = (ADDR_LEN'(pixel_y) * H_STRIDE) + ADDR_LEN'(pixel_x);
      data_d = pixel_color;
      cnt_d  = frame_done ? '0 : cnt_inc;
    end

    // Ready is registered from the upcoming state so it is glitch-free and
    // independent of pixel_valid.
    ready_d = (state_d != WAIT_VBLANK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      swap_q  <= 1'b0;
      frame_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      swap_q  <= swap_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign pixel_ready  = ready_q;
  assign write_enable = we_q;
  assign write_addr   = addr_q;
  assign write_data   = data_q;
  assign swap_buffers = swap_q;
  assign frame_count  = frame_q;
  assign range_error  = err_q;

endmodule

// File: tb/tb_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_frame_writer
//
// Directed bench for frame_writer. The frame height is reduced to 4 rows so
// several complete frames fit in a short run; the row stride stays at 320 so
// addresses match the full-size layout. Expected writes are queued when a
// pixel is driven and popped when the write strobe appears one cycle later.
// ---------------------------------------------------------------------------
module tb_frame_writer;

  localparam int WIDTH = 12;
  localparam int H     = 320;
  localparam int V     = 4;
  localparam int AL    = 17;
  localparam int TOTAL = H * V;

  localparam int S_WR   = 0;
  localparam int S_WAIT = 1;
  localparam int S_ARM  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             pixel_valid;
  logic             pixel_ready;
  logic [8:0]       pixel_x;
  logic [7:0]       pixel_y;
  logic [WIDTH-1:0] pixel_color;
  logic             vblank;
  logic             write_enable;
  logic [AL-1:0]    write_addr;
  logic [WIDTH-1:0] write_data;
  logic             swap_buffers;
  logic [7:0]       frame_count;
  logic             range_error;

  frame_writer #(
    .WIDTH(WIDTH), .H_PIXELS(H), .V_PIXELS(V), .ADDR_LEN(AL)
  ) dut (
    .clk(clk), .rst(rst),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
    .vblank(vblank),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .swap_buffers(swap_buffers), .frame_count(frame_count), .range_error(range_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AL-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  wr_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  int       m_st;
  int       m_cnt;
  bit       m_ready;
  bit       m_err;
  bit [7:0] m_frame;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st    = S_WR;
    m_cnt   = 0;
    m_ready = 1'b1;
    m_err   = 1'b0;
    m_frame = 8'd0;
    sb.delete();
  endtask

  // One clock: drive at the falling edge, predict, check 1 ns after the
  // rising edge, return at the next falling edge.
  task automatic step(input bit v, input int x, input int y,
                      input logic [WIDTH-1:0] c, input bit vb);
    bit  acc, inr, exp_we, exp_sw;
    wr_t e;
    pixel_valid = v;
    pixel_x     = 9'(x);
    pixel_y     = 8'(y);
    pixel_color = c;
    vblank      = vb;

    acc    = v && m_ready;
    inr    = (x < H) && (y < V);
    exp_we = acc && inr;
    exp_sw = acc && (m_st == S_ARM);
    if (exp_we) begin
      e.addr = AL'(y * H + x);
      e.data = c;
      sb.push_back(e);
    end

    if (acc && !inr) m_err = 1'b1;
    if (exp_sw) m_frame = m_frame + 8'd1;
    case (m_st)
      S_WR, S_ARM: begin
        if (acc) begin
          if (m_st == S_ARM) m_st = S_WR;
          if (inr) begin
            m_cnt++;
            if (m_cnt == TOTAL) begin
              m_cnt = 0;
              m_st  = S_WAIT;
            end
          end
        end
      end
      default: if (vb) m_st = S_ARM;
    endcase
    m_ready = (m_st != S_WAIT);

    @(posedge clk);
    #1;
    chk("write_enable", write_enable, exp_we);
    chk("swap_buffers", swap_buffers, exp_sw);
    if (exp_we) begin
      e = sb.pop_front();
      if (write_enable === 1'b1) begin
        chk("write_addr", write_addr, e.addr);
        chk("write_data", write_data, e.data);
      end
    end
    chk("pixel_ready", pixel_ready, m_ready);
    chk("frame_count", frame_count, m_frame);
    chk("range_error", range_error, m_err);
    @(negedge clk);
  endtask

  task automatic pixels(input int n, input bit vb);
    for (int i = 0; i < n; i++) begin
      if (i % 7 == 3) step(1'b0, 0, 0, '0, vb);
      step(1'b1, i % H, (i / H) % V, WIDTH'($urandom), vb);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_we"},    write_enable, 0);
    chk({tag, "_addr"},  write_addr,   0);
    chk({tag, "_data"},  write_data,   0);
    chk({tag, "_swap"},  swap_buffers, 0);
    chk({tag, "_frame"}, frame_count,  0);
    chk({tag, "_err"},   range_error,  0);
  endtask

  initial begin
    rst         = 1'b1;
    pixel_valid = 1'b0;
    pixel_x     = '0;
    pixel_y     = '0;
    pixel_color = '0;
    vblank      = 1'b0;
    model_reset();
    #3;
    check_cleared("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("por_ready", pixel_ready, 1);

    // single write: (5,2) -> 645
    step(1'b1, 5, 2, 12'hABC, 1'b0);
    chk("s1_addr", write_addr, 645);
    chk("s1_data", write_data, 12'hABC);
    step(1'b0, 0, 0, '0, 1'b0);
    chk("s1_idle_we", write_enable, 0);

    // out-of-range drops, sticky error, count unaffected
    step(1'b1, 320, 0, 12'h111, 1'b0);
    chk("s4_err_x", range_error, 1);
    step(1'b1, 0, 240, 12'h222, 1'b0);
    step(1'b1, 0, V, 12'h333, 1'b0);
    chk("s4_no_we", write_enable, 0);
    step(1'b1, H - 1, V - 1, 12'h444, 1'b0);
    chk("s4_corner_addr", write_addr, TOTAL - 1);
    chk("s4_err_sticky", range_error, 1);

    // finish the frame (2 pixels already counted), vblank low -> stall
    pixels(TOTAL - 2, 1'b0);
    chk("s2_ready_low", pixel_ready, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1, 12'h555, 1'b0);
    chk("s2_no_we", write_enable, 0);
    chk("s2_no_swap", swap_buffers, 0);

    // one-cycle vblank, then (0,0) swaps
    step(1'b0, 0, 0, '0, 1'b1);
    chk("s3_ready", pixel_ready, 1);
    step(1'b1, 0, 0, 12'h0F0, 1'b0);
    chk("s3_swap", swap_buffers, 1);
    chk("s3_we", write_enable, 1);
    chk("s3_addr", write_addr, 0);
    chk("s3_frame", frame_count, 1);
    step(1'b0, 0, 0, '0, 1'b0);
    chk("s3_swap_once", swap_buffers, 0);

    // vblank held through frame completion -> armed 2 cycles after last accept
    pixels(TOTAL - 1, 1'b1);
    chk("s5_ready_c1", pixel_ready, 0);
    step(1'b0, 0, 0, '0, 1'b1);
    chk("s5_ready_c2", pixel_ready, 1);
    step(1'b1, 400, 0, 12'h777, 1'b0);
    chk("s5_swap_oor", swap_buffers, 1);
    chk("s5_we_oor", write_enable, 0);
    chk("s5_frame", frame_count, 2);

    // out-of-range swap pixel did not count: full frame needed, then reset in WAIT
    pixels(TOTAL, 1'b0);
    chk("s6_in_wait", pixel_ready, 0);
    #2 rst = 1'b1;
    #1;
    check_cleared("s6_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("s6_ready", pixel_ready, 1);
    pixels(TOTAL - 1, 1'b0);
    step(1'b0, 0, 0, '0, 1'b1);
    chk("s6_not_done", pixel_ready, 1);
    step(1'b1, 7, 3, 12'h999, 1'b0);
    chk("s6_no_swap_first", swap_buffers, 0);
    chk("s6_done", pixel_ready, 0);
    step(1'b0, 0, 0, '0, 1'b1);
    step(1'b1, 2, 1, 12'hABC, 1'b0);
    chk("s6_swap", swap_buffers, 1);
    chk("s6_frame", frame_count, 1);
    step(1'b0, 0, 0, '0, 1'b0);

    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
